// File: rtl/program_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// gpu_pkg
//   Definitions shared by the program-memory arbiter files. The package keeps
//   the gpu_pkg name so other blocks of the core array can import the same
//   channel-state encoding and reset polarity.
//   - chan_state_e : per-channel read FSM encoding
//   - RESET_ACTIVE : level of the reset input that holds the block in reset
// ----------------------------------------------------------------------------
package gpu_pkg;

    localparam logic RESET_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,  // free, may be granted to an eligible fetcher
        READ_WAITING = 2'b01,  // memory request outstanding
        RELAYING     = 2'b10   // word presented to the fetcher, waiting for it to drop valid
    } chan_state_e;

endpackage

// File: rtl/program_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// program_mem_arbiter_if
//   Bundles the fetcher-side and memory-side read buses of the arbiter.
//   All vectors are packed per consumer / per channel, element i occupying
//   [i*WIDTH +: WIDTH].
//   - slave  : arbiter view (takes fetcher requests, drives memory requests)
//   - master : environment view (fetchers and program memory)
// ----------------------------------------------------------------------------
interface program_mem_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);

    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;

    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data
    );

endinterface

// File: rtl/program_mem_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin search: finds the first set bit of mask_i
//   starting at start_i and wrapping modulo N.
//   - start_i : index where the search begins
//   - mask_i  : eligibility mask
//   - found_o : some bit of mask_i is set
//   - idx_o   : index of the first set bit at or after start_i (0 if none)
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] start_i,
    input  logic [N-1:0]     mask_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // so no path through the block leaves a value held (no latch).
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        // Walk from the farthest offset down so the nearest hit wins last.
        for (int off = N - 1; off >= 0; off--) begin
            cand = (int'(start_i) + off) % N;
            if (mask_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// ----------------------------------------------------------------------------
// program_mem_arbiter
//   Shares NUM_CHANNELS program-memory read channels among NUM_CONSUMERS
//   instruction fetchers. Idle channels are granted round-robin; each channel
//   runs IDLE -> READ_WAITING -> RELAYING and hands the fetched word back to
//   the fetcher that owns it.
//   Ports:
//   - clk   : rising-edge clock
//   - reset : asynchronous reset, active low
//   - bus   : fetcher and memory read buses (slave view)
// ----------------------------------------------------------------------------
module program_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    program_mem_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    chan_state_e                        st_q      [NUM_CHANNELS];
    chan_state_e                        st_d      [NUM_CHANNELS];
    idx_t                               owner_q   [NUM_CHANNELS];
    idx_t                               owner_d   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]            mem_valid_q, mem_valid_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]           busy_q, busy_d;
    logic [NUM_CONSUMERS-1:0]           cons_ready_q, cons_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_data_q, cons_data_d;
    idx_t                               rr_ptr_q, rr_ptr_d;

    logic [NUM_CHANNELS-1:0]            grant;
    idx_t                               pick_idx  [NUM_CHANNELS];

    // ------------------------------------------------------------------
    // Arbitration chain: each channel searches the eligibility left over
    // after all lower channels have taken their pick this cycle.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        logic [NUM_CONSUMERS-1:0] elig_in;
        logic [NUM_CONSUMERS-1:0] elig_out;
        logic                     found;

        if (ch == 0) begin : g_first
            assign elig_in = bus.consumer_read_valid & ~busy_q;
        end else begin : g_rest
            assign elig_in = g_chan[ch-1].elig_out;
        end

        rr_picker #(
            .N     (NUM_CONSUMERS),
            .IDX_W (IDX_W)
        ) u_picker (
            .start_i (rr_ptr_q),
            .mask_i  (elig_in),
            .found_o (found),
            .idx_o   (pick_idx[ch])
        );

        assign grant[ch] = (st_q[ch] == IDLE) && found;
        assign elig_out  = grant[ch]
                         ? (elig_in & ~(NUM_CONSUMERS'(1) << pick_idx[ch]))
                         : elig_in;
    end

    // ------------------------------------------------------------------
    // Channel FSMs, busy mask, fetcher outputs and round-robin pointer.
    // ------------------------------------------------------------------
    always_comb begin
        st_d         = st_q;
        owner_d      = owner_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        cons_ready_d = cons_ready_q;
        cons_data_d  = cons_data_q;
        rr_ptr_d     = rr_ptr_q;

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            unique case (st_q[ch])
                IDLE: begin
                    if (grant[ch]) begin
                        st_d[ch]        = READ_WAITING;
                        owner_d[ch]     = pick_idx[ch];
                        mem_valid_d[ch] = 1'b1;
                        // Address is captured only here; later changes by
                        // the fetcher are ignored until its next grant.
                        mem_addr_d[ch*ADDR_BITS +: ADDR_BITS] =
                            bus.consumer_read_address[pick_idx[ch]*ADDR_BITS +: ADDR_BITS];
                        busy_d[pick_idx[ch]] = 1'b1;
                        // Channels are visited in ascending order, so the
                        // highest granting channel sets the pointer.
                        if (pick_idx[ch] == idx_t'(NUM_CONSUMERS - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = pick_idx[ch] + 1'b1;
                        end
                    end
                end

                READ_WAITING: begin
                    // Completes even if the fetcher already dropped valid;
                    // RELAYING then releases it after a single ready cycle.
                    if (bus.mem_read_ready[ch]) begin
                        st_d[ch]                 = RELAYING;
                        mem_valid_d[ch]          = 1'b0;
                        cons_ready_d[owner_q[ch]] = 1'b1;
                        cons_data_d[owner_q[ch]*DATA_BITS +: DATA_BITS] =
                            bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
                    end
                end

                RELAYING: begin
                    if (!bus.consumer_read_valid[owner_q[ch]]) begin
                        st_d[ch]                 = IDLE;
                        cons_ready_d[owner_q[ch]] = 1'b0;
                        busy_d[owner_q[ch]]       = 1'b0;
                    end
                end

                default: begin
                    st_d[ch]        = IDLE;
                    mem_valid_d[ch] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            // NOTE: the data registers are reset too because the fetcher and
            // memory buses must read all-zero while reset is asserted.
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                st_q[ch]    <= IDLE;
                owner_q[ch] <= '0;
            end
            mem_valid_q  <= '0;
            mem_addr_q   <= '0;
            busy_q       <= '0;
            cons_ready_q <= '0;
            cons_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            st_q         <= st_d;
            owner_q      <= owner_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            cons_ready_q <= cons_ready_d;
            cons_data_q  <= cons_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.mem_read_valid      = mem_valid_q;
    assign bus.mem_read_address    = mem_addr_q;
    assign bus.consumer_read_ready = cons_ready_q;
    assign bus.consumer_read_data  = cons_data_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_program_mem_arbiter
//   Directed bench for program_mem_arbiter. dut1 has one memory channel and
//   a behavioural memory with programmable latency; dut2 has two channels and
//   its memory side is driven by hand. Outputs are sampled on the falling
//   edge, inputs are driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_program_mem_arbiter;

    logic clk;
    logic reset;

    program_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) bus1 ();
    program_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bus2 ();

    program_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    program_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat1 = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory contents seen by dut1.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (a == 8'h3A) ? 16'hBEEF : {a, ~a};
    endfunction

    // Memory for dut1: ready after mem_lat1 sampled cycles of a pending request.
    initial begin : mem_model1
        int cnt;
        cnt = 0;
        bus1.mem_read_ready = '0;
        bus1.mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (bus1.mem_read_valid[0]) begin
                if (cnt >= mem_lat1) begin
                    bus1.mem_read_ready = 1'b1;
                    bus1.mem_read_data  = mem_word(bus1.mem_read_address[7:0]);
                end else begin
                    bus1.mem_read_ready = 1'b0;
                    cnt++;
                end
            end else begin
                bus1.mem_read_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic set_cons1(input int i, input logic [7:0] a, input logic v);
        bus1.consumer_read_address[i*8 +: 8] = a;
        bus1.consumer_read_valid[i]          = v;
    endtask

    task automatic wait_mem_valid1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.mem_read_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cons_ready1(output bit ok, output int idx);
        ok  = 1'b0;
        idx = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (|bus1.consumer_read_ready) begin
                ok = 1'b1;
                for (int c = 3; c >= 0; c--) if (bus1.consumer_read_ready[c]) idx = c;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  mask;      // fetchers requesting during this step
        int          lat;       // memory wait cycles
        int          exp_cons;  // fetcher expected to be served
        logic [7:0]  exp_addr;  // address expected on the memory bus
        logic [15:0] exp_data;  // word expected back at that fetcher
    } vec_t;

    vec_t vecs [11];

    initial begin : main
        bit   ok;
        int   idx;
        bit   stable;

        // Round-robin with all fetchers requesting, then sparse masks.
        vecs[0]  = '{4'b1111, 3, 0, 8'h10, 16'h10EF};
        vecs[1]  = '{4'b1111, 3, 1, 8'h11, 16'h11EE};
        vecs[2]  = '{4'b1111, 3, 2, 8'h12, 16'h12ED};
        vecs[3]  = '{4'b1111, 3, 3, 8'h13, 16'h13EC};
        vecs[4]  = '{4'b1111, 3, 0, 8'h10, 16'h10EF};
        vecs[5]  = '{4'b1111, 3, 1, 8'h11, 16'h11EE};
        vecs[6]  = '{4'b1111, 3, 2, 8'h12, 16'h12ED};
        vecs[7]  = '{4'b1111, 3, 3, 8'h13, 16'h13EC};
        vecs[8]  = '{4'b1010, 1, 1, 8'h11, 16'h11EE};
        vecs[9]  = '{4'b0011, 0, 0, 8'h10, 16'h10EF};
        vecs[10] = '{4'b1000, 2, 3, 8'h13, 16'h13EC};

        reset = 1'b0;
        bus1.consumer_read_valid   = '0;
        bus1.consumer_read_address = '0;
        bus2.consumer_read_valid   = '0;
        bus2.consumer_read_address = '0;
        bus2.mem_read_ready        = '0;
        bus2.mem_read_data         = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_cons_ready", 64'(bus1.consumer_read_ready), 64'h0);
        check("rst_cons_data",  64'(bus1.consumer_read_data),  64'h0);
        check("rst_mem_valid",  64'(bus1.mem_read_valid),      64'h0);
        check("rst_mem_addr",   64'(bus1.mem_read_address),    64'h0);
        check("rst2_mem_valid", 64'(bus2.mem_read_valid),      64'h0);
        reset = 1'b1;

        // ---------------- single read, zero-wait memory ----------------
        @(negedge clk);
        mem_lat1 = 0;
        set_cons1(2, 8'h3A, 1'b1);
        @(negedge clk);
        check("single_mem_valid",   64'(bus1.mem_read_valid),   64'h1);
        check("single_mem_addr",    64'(bus1.mem_read_address), 64'h3A);
        check("single_ready_early", 64'(bus1.consumer_read_ready), 64'h0);
        @(negedge clk);
        check("single_ready",       64'(bus1.consumer_read_ready), 64'b0100);
        check("single_data",        64'(bus1.consumer_read_data[32 +: 16]), 64'hBEEF);
        check("single_mem_dropped", 64'(bus1.mem_read_valid), 64'h0);
        bus1.consumer_read_valid[2] = 1'b0;
        @(negedge clk);
        check("single_ready_clr",   64'(bus1.consumer_read_ready), 64'h0);
        check("single_busy_clr",    64'(dut1.busy_q), 64'h0);
        check("single_data_kept",   64'(bus1.consumer_read_data[32 +: 16]), 64'hBEEF);

        // Restart from a known pointer for the round-robin table.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_cons1(i, 8'(8'h10 + i), 1'b0);

        // ---------------- table-driven round-robin ----------------
        for (int k = 0; k < 11; k++) begin
            mem_lat1 = vecs[k].lat;
            bus1.consumer_read_valid = vecs[k].mask;
            wait_mem_valid1(ok);
            check($sformatf("v%0d_grant_seen", k), 64'(ok), 64'h1);
            check($sformatf("v%0d_mem_addr", k), 64'(bus1.mem_read_address), 64'(vecs[k].exp_addr));
            wait_cons_ready1(ok, idx);
            check($sformatf("v%0d_ready_seen", k), 64'(ok), 64'h1);
            check($sformatf("v%0d_served", k), 64'(idx), 64'(vecs[k].exp_cons));
            check($sformatf("v%0d_data", k), 64'(bus1.consumer_read_data[idx*16 +: 16]), 64'(vecs[k].exp_data));
            bus1.consumer_read_valid[idx] = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ready_clr", k), 64'(bus1.consumer_read_ready), 64'h0);
        end
        bus1.consumer_read_valid = '0;

        // ---------------- hold stability + address aliasing ----------------
        mem_lat1 = 10;
        set_cons1(1, 8'h55, 1'b1);
        wait_mem_valid1(ok);
        check("hold_grant_seen", 64'(ok), 64'h1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (!(bus1.mem_read_valid[0] && bus1.mem_read_address == 8'h55)) stable = 1'b0;
            if (i == 0) set_cons1(1, 8'h66, 1'b1);
        end
        check("hold_stable", 64'(stable), 64'h1);
        wait_cons_ready1(ok, idx);
        check("hold_served", 64'(idx), 64'd1);
        check("hold_data",   64'(bus1.consumer_read_data[16 +: 16]), 64'h55AA);
        bus1.consumer_read_valid[1] = 1'b0;
        @(negedge clk);

        // ---------------- abort during READ_WAITING ----------------
        mem_lat1 = 3;
        set_cons1(0, 8'h20, 1'b1);
        set_cons1(1, 8'h21, 1'b1);
        wait_mem_valid1(ok);
        check("abort_grant_seen", 64'(ok), 64'h1);
        check("abort_mem_addr",   64'(bus1.mem_read_address), 64'h20);
        bus1.consumer_read_valid[0] = 1'b0;
        wait_cons_ready1(ok, idx);
        check("abort_served",   64'(idx), 64'd0);
        check("abort_data",     64'(bus1.consumer_read_data[0 +: 16]), 64'h20DF);
        @(negedge clk);
        check("abort_one_cycle", 64'(bus1.consumer_read_ready), 64'h0);
        check("abort_c3_untouched", 64'(bus1.consumer_read_data[48 +: 16]), 64'h13EC);
        wait_mem_valid1(ok);
        check("abort_next_addr", 64'(bus1.mem_read_address), 64'h21);
        wait_cons_ready1(ok, idx);
        check("abort_next_served", 64'(idx), 64'd1);
        check("abort_next_data",   64'(bus1.consumer_read_data[16 +: 16]), 64'h21DE);
        bus1.consumer_read_valid[1] = 1'b0;
        @(negedge clk);

        // ---------------- reset in the middle of a read ----------------
        mem_lat1 = 5;
        set_cons1(3, 8'h30, 1'b1);
        wait_mem_valid1(ok);
        check("rstmid_mem_addr", 64'(bus1.mem_read_address), 64'h30);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_mem_valid",  64'(bus1.mem_read_valid),      64'h0);
        check("rstmid_mem_addr0",  64'(bus1.mem_read_address),    64'h0);
        check("rstmid_cons_ready", 64'(bus1.consumer_read_ready), 64'h0);
        check("rstmid_cons_data",  64'(bus1.consumer_read_data),  64'h0);
        @(negedge clk);
        mem_lat1 = 0;
        reset = 1'b1;
        wait_mem_valid1(ok);
        check("rstmid_again_addr", 64'(bus1.mem_read_address), 64'h30);
        wait_cons_ready1(ok, idx);
        check("rstmid_again_served", 64'(idx), 64'd3);
        check("rstmid_again_data",   64'(bus1.consumer_read_data[48 +: 16]), 64'h30CF);
        bus1.consumer_read_valid[3] = 1'b0;
        @(negedge clk);

        // ---------------- dual channel, simultaneous requests ----------------
        bus2.consumer_read_address = {8'h43, 8'h00, 8'h41, 8'h00};
        bus2.consumer_read_valid   = 4'b1010;
        @(negedge clk);
        check("dual_mem_valid", 64'(bus2.mem_read_valid), 64'b11);
        check("dual_ch0_addr",  64'(bus2.mem_read_address[7:0]),  64'h41);
        check("dual_ch1_addr",  64'(bus2.mem_read_address[15:8]), 64'h43);
        check("dual_rr_ptr",    64'(dut2.rr_ptr_q), 64'h0);
        bus2.mem_read_ready = 2'b11;
        bus2.mem_read_data  = {16'h3333, 16'h1111};
        @(negedge clk);
        check("dual_ready",   64'(bus2.consumer_read_ready), 64'b1010);
        check("dual_data1",   64'(bus2.consumer_read_data[16 +: 16]), 64'h1111);
        check("dual_data3",   64'(bus2.consumer_read_data[48 +: 16]), 64'h3333);
        check("dual_mem_off", 64'(bus2.mem_read_valid), 64'h0);
        bus2.mem_read_ready      = '0;
        bus2.consumer_read_valid = '0;
        @(negedge clk);
        check("dual_ready_clr", 64'(bus2.consumer_read_ready), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_mem_arbiter.md
Name: program_mem_arbiter

Overview:
- Shares the program-memory read port(s) between the per-core instruction fetchers.
- Each fetcher is a consumer: it raises a read request with an address, holds it until ready, then drops the request.
- The block grants consumers round-robin onto NUM_CHANNELS memory channels, performs a valid/ready read per channel, and returns each instruction word to the requesting fetcher.
- Sits between the core array and the external program memory.

Parameters:
- ADDR_BITS, 8, program memory address width.
- DATA_BITS, 16, instruction word width.
- NUM_CONSUMERS, 4, number of fetchers served; at least 1.
- NUM_CHANNELS, 1, concurrent program-memory read channels; 1 to NUM_CONSUMERS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  per-fetcher data-valid/ready.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed, same slicing as the address.
- mem_read_valid  out  NUM_CHANNELS  per-channel memory request.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed per channel.
- mem_read_ready  in  NUM_CHANNELS  memory response strobe.
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory response data; valid when ready is 1.

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs 0: consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address.
  - Every channel goes to IDLE; busy mask cleared; round-robin pointer = 0.
  - Any in-flight transaction is abandoned.
- Per-channel FSM states: IDLE, READ_WAITING, RELAYING.
- IDLE:
  - A consumer is eligible if its valid is 1 and its busy bit is 0.
  - If the channel picks a consumer c: register mem_read_valid=1, mem_read_address=addr[c], set busy[c], record c, go to READ_WAITING.
- READ_WAITING:
  - Hold mem_read_valid and address stable until the edge where mem_read_ready==1.
  - On that edge: mem_read_valid<=0, consumer_read_data[c]<=mem_read_data, consumer_read_ready[c]<=1, go to RELAYING.
- RELAYING:
  - Hold consumer_read_ready[c] and its data.
  - On the first edge where consumer_read_valid[c]==0: ready[c]<=0, clear busy[c], go to IDLE.
  - consumer_read_data[c] retains its last value afterwards.
- Arbitration (same cycle, deterministic):
  - IDLE channels are visited in ascending channel index.
  - Each channel searches consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS.
  - A consumer picked by a lower channel in the same cycle is excluded for higher channels. No consumer is ever held by two channels.
  - If any grant occurs, rr_ptr <= (last granted index + 1) mod NUM_CONSUMERS; otherwise rr_ptr is unchanged.
- Latency (single channel, zero-wait memory):
  - Consumer valid seen at edge E → mem_read_valid high after E.
  - Memory ready at edge E+1 → consumer ready high after E+1.
  - Best-case request-to-ready is 2 cycles.
- Back-to-back reuse: a channel freed at edge E may be granted at edge E+1, but not at E.
- Fairness: with all consumers requesting continuously, NUM_CHANNELS=1 serves 0,1,2,3,0,…
- Protocol violation: if a consumer drops valid while its read is in READ_WAITING, the memory read still completes. The channel then enters RELAYING, sees valid==0, and returns to IDLE after one ready cycle. No hang and no effect on other consumers.
- Request aliasing: the consumer address is sampled only at grant. Later changes are ignored until the next grant.
- The outputs of ungranted consumers never change.

Decomposition:
- Shared package gpu_pkg holds:
  - the channel state encoding (IDLE=2'b00, READ_WAITING=2'b01, RELAYING=2'b10);
  - reset-polarity constant RESET_ACTIVE=1'b0.
- Natural sub-module rr_picker: combinational first-set search from a start index over an eligibility mask, returning found and index. Instantiated once per channel, in a chain with a masked eligibility vector.

Test Plan:
- Single read: NUM_CHANNELS=1, consumer 2 requests addr 0x3A; memory returns 0xBEEF with zero wait → mem_read_address=0x3A one cycle after valid; consumer_read_ready[2]=1 with data 0xBEEF one cycle later; busy cleared one cycle after valid drops.
- Round-robin: all 4 consumers request at addresses 0x10..0x13, each memory response 3 cycles late → grant order 0,1,2,3; repeated requests continue 0,1,2,3 with no starvation.
- Dual channel: NUM_CHANNELS=2, consumers 1 and 3 request in the same cycle → channel 0 takes 1 and channel 1 takes 3 in that cycle; both outstanding; rr_ptr becomes 0.
- Reset mid-operation: pull reset low while in READ_WAITING → mem_read_valid and consumer_read_ready go to 0 immediately, without waiting for a clock; after release a new request is served normally.
- Abort: consumer 0 drops valid during READ_WAITING → memory read completes, ready[0] high exactly one cycle, channel returns to IDLE and serves consumer 1's pending request next.
- Hold stability: memory ready withheld 10 cycles → mem_read_valid and address remain constant throughout.
